// File: rtl/mips_program_loader_if.sv
//==============================================================================
// mips_program_loader_if
// Byte-stream input, instruction-memory write port and core-control bundle.
// Rev 1.0
//==============================================================================
`default_nettype none

interface mips_program_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              cpu_start;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start,
               busy, done, error, words_loaded
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, cpu_start,
               busy, done, error, words_loaded
    );
endinterface

`default_nettype wire

// File: rtl/mips_program_loader.sv
//==============================================================================
// mips_program_loader
// Assembles a framed big-endian byte stream into instruction words and releases
// the core with a one-cycle start pulse once the frame checksum verifies.
// Rev 1.0
//==============================================================================
`default_nettype none

module mips_program_loader #(
    parameter int ADDR_W = 10
) (
    input  logic                 clk1,
    input  logic                 rst,
    mips_program_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [31:0]     C_CAPACITY = 32'd1 << ADDR_W;
    localparam logic [ADDR_W:0] C_ONE      = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [7:0]        nhi_q, nhi_d;
    logic [7:0]        xor_q, xor_d;
    logic [ADDR_W:0]   nwords_q, nwords_d;
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       asm_q, asm_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              hold_q, hold_d;
    logic              cstart_q, cstart_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              w_active;
    logic              w_accept;
    logic [31:0]       w_nfull;
    logic [ADDR_W:0]   w_idx_inc;

    assign w_active = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
    assign w_accept  = bus.in_valid && w_active;
    assign w_nfull   = {16'd0, nhi_q, bus.in_data};
    assign w_idx_inc = word_idx_q + C_ONE;

    assign bus.in_ready     = w_active;
    assign bus.busy         = w_active;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.cpu_hold     = hold_q;
    assign bus.cpu_start    = cstart_q;
    assign bus.done         = done_q;
    assign bus.error        = err_q;
    assign bus.words_loaded = words_q;

    always_comb begin
        state_d     = state_q;
        nhi_d       = nhi_q;
        xor_d       = xor_q;
        nwords_d    = nwords_q;
        word_idx_d  = word_idx_q;
        words_d     = words_q;
        bcnt_d      = bcnt_q;
        asm_d       = asm_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hold_d      = hold_q;
        cstart_d    = 1'b0;
        done_d      = done_q;
        err_d       = err_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d    = S_HDR0;
                    xor_d      = 8'd0;
                    word_idx_d = '0;
                    words_d    = '0;
                    bcnt_d     = 2'd0;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    hold_d     = 1'b1;
                end
            end
            S_HDR0: begin
                if (w_accept) begin
                    nhi_d   = bus.in_data;
                    xor_d   = xor_q ^ bus.in_data;
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (w_accept) begin
                    xor_d    = xor_q ^ bus.in_data;
                    nwords_d = w_nfull[ADDR_W:0];
                    // Exactly 2^ADDR_W words is legal: word_idx is one bit wider than the address.
                    if (w_nfull > C_CAPACITY) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (w_nfull == 32'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    xor_d  = xor_q ^ bus.in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    asm_d  = {asm_q[15:0], bus.in_data};
                    if (bcnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_idx_q[ADDR_W-1:0];
                        mem_wdata_d = {asm_q, bus.in_data};
                        word_idx_d  = w_idx_inc;
                        words_d     = w_idx_inc;
                        if (w_idx_inc == nwords_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    if (bus.in_data == xor_q) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        hold_d   = 1'b0;
                        cstart_d = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            nhi_q       <= 8'd0;
            xor_q       <= 8'd0;
            nwords_q    <= '0;
            word_idx_q  <= '0;
            words_q     <= '0;
            bcnt_q      <= 2'd0;
            asm_q       <= 24'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            hold_q      <= 1'b1;
            cstart_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            nhi_q       <= nhi_d;
            xor_q       <= xor_d;
            nwords_q    <= nwords_d;
            word_idx_q  <= word_idx_d;
            words_q     <= words_d;
            bcnt_q      <= bcnt_d;
            asm_q       <= asm_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hold_q      <= hold_d;
            cstart_q    <= cstart_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mips_program_loader.sv
//==============================================================================
// tb_mips_program_loader
// Frame-level model plus directed frames on a default-width and a 2-bit-address loader.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_mips_program_loader;
    localparam int AW0 = 10;
    localparam int AW1 = 2;

    logic clk1 = 1'b0;
    logic rst  = 1'b0;
    always #5 clk1 = ~clk1;

    logic [1:0] st_i = 2'b00;
    logic [1:0] v_i  = 2'b00;
    logic [7:0] d_i [2];

    mips_program_loader_if #(.ADDR_W(AW0)) if0 ();
    mips_program_loader_if #(.ADDR_W(AW1)) if1 ();

    mips_program_loader #(.ADDR_W(AW0)) dut0 (.clk1(clk1), .rst(rst), .bus(if0.slave));
    mips_program_loader #(.ADDR_W(AW1)) dut1 (.clk1(clk1), .rst(rst), .bus(if1.slave));

    assign if0.start = st_i[0];  assign if0.in_valid = v_i[0];  assign if0.in_data = d_i[0];
    assign if1.start = st_i[1];  assign if1.in_valid = v_i[1];  assign if1.in_data = d_i[1];

    logic [1:0]  o_rdy, o_busy, o_we, o_hold, o_cs, o_done, o_err;
    logic [9:0]  o_addr [2];
    logic [31:0] o_wd   [2];
    logic [10:0] o_wl   [2];

    assign o_rdy  = {if1.in_ready,  if0.in_ready};
    assign o_busy = {if1.busy,      if0.busy};
    assign o_we   = {if1.mem_we,    if0.mem_we};
    assign o_hold = {if1.cpu_hold,  if0.cpu_hold};
    assign o_cs   = {if1.cpu_start, if0.cpu_start};
    assign o_done = {if1.done,      if0.done};
    assign o_err  = {if1.error,     if0.error};
    assign o_addr[0] = if0.mem_addr;
    assign o_addr[1] = {8'd0, if1.mem_addr};
    assign o_wd[0]   = if0.mem_wdata;
    assign o_wd[1]   = if1.mem_wdata;
    assign o_wl[0]   = if0.words_loaded;
    assign o_wl[1]   = {8'd0, if1.words_loaded};

    int n_pass  = 0;
    int n_total = 0;
    int sc [2];
    int wc [2];
    logic [31:0] tmem0 [0:1023];
    logic [31:0] tmem1 [0:3];

    // Frame-level model: tracks accepted bytes and derives writes/outcome from the frame rules.
    int          cap [2] = '{1024, 4};
    bit          m_act [2];
    int          m_k [2];
    int          m_n [2];
    logic [7:0]  m_fr [2][64];
    bit          e_we [2], e_hold [2], e_cs [2], e_done [2], e_err [2];
    int          e_addr [2], e_wl [2];
    logic [31:0] e_wd [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic m_reset(input int d);
        m_act[d] = 0; m_k[d] = 0; m_n[d] = 0;
        e_we[d] = 0; e_hold[d] = 1; e_cs[d] = 0; e_done[d] = 0; e_err[d] = 0;
        e_addr[d] = 0; e_wl[d] = 0; e_wd[d] = 32'd0;
    endtask

    task automatic m_step(input int d);
        logic [7:0] x;
        int k;
        e_we[d] = 0;
        e_cs[d] = 0;
        if (!m_act[d]) begin
            if (st_i[d]) begin
                m_act[d] = 1; m_k[d] = 0;
                e_done[d] = 0; e_err[d] = 0; e_hold[d] = 1; e_wl[d] = 0;
            end
        end else if (v_i[d] && m_k[d] < 64) begin
            m_fr[d][m_k[d]] = d_i[d];
            m_k[d]++;
            k = m_k[d];
            if (k == 2) begin
                m_n[d] = 256 * int'(m_fr[d][0]) + int'(m_fr[d][1]);
                if (m_n[d] > cap[d]) begin
                    m_act[d] = 0; e_err[d] = 1;
                end
            end else if (k > 2 && k <= 2 + 4 * m_n[d]) begin
                if ((k - 2) % 4 == 0) begin
                    e_we[d]   = 1;
                    e_addr[d] = (k - 2) / 4 - 1;
                    e_wd[d]   = {m_fr[d][k-4], m_fr[d][k-3], m_fr[d][k-2], m_fr[d][k-1]};
                    e_wl[d]   = (k - 2) / 4;
                end
            end else if (k == 3 + 4 * m_n[d]) begin
                x = 8'd0;
                for (int i = 0; i < k - 1; i++) x = x ^ m_fr[d][i];
                m_act[d] = 0;
                if (x == m_fr[d][k-1]) begin
                    e_done[d] = 1; e_hold[d] = 0; e_cs[d] = 1;
                end else begin
                    e_err[d] = 1;
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) m_reset(d);
        forever begin
            @(posedge clk1 or posedge rst);
            for (int d = 0; d < 2; d++) begin
                if (rst) m_reset(d);
                else     m_step(d);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk1);
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("in_ready%0d", d), 32'(o_rdy[d]),  32'(m_act[d]));
                chk($sformatf("busy%0d", d),     32'(o_busy[d]), 32'(m_act[d]));
                chk($sformatf("mem_we%0d", d),   32'(o_we[d]),   32'(e_we[d]));
                if (e_we[d]) begin
                    chk($sformatf("mem_addr%0d", d),  32'(o_addr[d]), 32'(e_addr[d]));
                    chk($sformatf("mem_wdata%0d", d), o_wd[d],        e_wd[d]);
                end
                chk($sformatf("cpu_hold%0d", d),  32'(o_hold[d]), 32'(e_hold[d]));
                chk($sformatf("cpu_start%0d", d), 32'(o_cs[d]),   32'(e_cs[d]));
                chk($sformatf("done%0d", d),      32'(o_done[d]), 32'(e_done[d]));
                chk($sformatf("error%0d", d),     32'(o_err[d]),  32'(e_err[d]));
                chk($sformatf("words_loaded%0d", d), 32'(o_wl[d]), 32'(e_wl[d]));
                if (o_cs[d]) sc[d]++;
                if (o_we[d]) begin
                    wc[d]++;
                    if (d == 0) tmem0[o_addr[0]] = o_wd[0];
                    else        tmem1[o_addr[1][1:0]] = o_wd[1];
                end
            end
        end
    end

    task automatic start_load(input int d, input bit with_byte);
        @(negedge clk1);
        st_i[d] = 1'b1; v_i[d] = with_byte; d_i[d] = 8'hFF;
        @(posedge clk1);
    endtask

    task automatic send(input int d, input logic [7:0] b, input bit st_also);
        int t;
        t = 0;
        @(negedge clk1);
        st_i[d] = st_also; v_i[d] = 1'b1; d_i[d] = b;
        while (!o_rdy[d] && t < 20) begin
            @(negedge clk1);
            st_i[d] = 1'b0;
            t++;
        end
        if (!o_rdy[d]) begin
            n_total++;
            $display("FAIL send_timeout dut%0d: in_ready 0, required 1", d);
            v_i[d] = 1'b0;
        end else begin
            @(posedge clk1);
        end
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) begin
            @(negedge clk1);
            st_i[d] = 1'b0; v_i[d] = 1'b0;
            @(posedge clk1);
        end
    endtask

    task automatic send_frame(input int d, input logic [7:0] q[$], input bit stall);
        foreach (q[i]) begin
            send(d, q[i], 1'b0);
            if (stall) idle(d, 1);
        end
        idle(d, 2);
    endtask

    task automatic clr_counts();
        sc[0] = 0; sc[1] = 0; wc[0] = 0; wc[1] = 0;
    endtask

    logic [7:0] good [$];
    logic [7:0] bad  [$];
    logic [7:0] fr   [$];

    initial begin
        d_i[0] = 8'd0; d_i[1] = 8'd0;
        clr_counts();
        for (int i = 0; i < 1024; i++) tmem0[i] = 32'd0;
        for (int i = 0; i < 4; i++)    tmem1[i] = 32'd0;
        good = '{8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0A, 8'h28, 8'h02, 8'h00, 8'h14, 8'h1F};
        bad  = '{8'h00, 8'h02, 8'h28, 8'h01, 8'h00, 8'h0A, 8'h28, 8'h02, 8'h00, 8'h14, 8'h1E};

        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(if0.in_ready), 32'd0);
        chk("rst_mem_we",   32'(if0.mem_we),   32'd0);
        chk("rst_mem_addr", 32'(if0.mem_addr), 32'd0);
        chk("rst_wdata",    if0.mem_wdata,     32'd0);
        chk("rst_hold",     32'(if0.cpu_hold), 32'd1);
        chk("rst_cstart",   32'(if0.cpu_start), 32'd0);
        chk("rst_busy",     32'(if0.busy),     32'd0);
        chk("rst_done",     32'(if0.done),     32'd0);
        chk("rst_error",    32'(if0.error),    32'd0);
        chk("rst_words",    32'(if0.words_loaded), 32'd0);
        @(negedge clk1); #2 rst = 1'b0;

        // Good 2-word load
        clr_counts();
        start_load(0, 1'b0);
        send_frame(0, good, 1'b0);
        chk("good_mem0", tmem0[0], 32'h2801000A);
        chk("good_mem1", tmem0[1], 32'h28020014);
        chk("good_words", 32'(if0.words_loaded), 32'd2);
        chk("good_done",  32'(if0.done), 32'd1);
        chk("good_hold",  32'(if0.cpu_hold), 32'd0);
        chk("good_pulses", 32'(sc[0]), 32'd1);

        // Bad checksum
        clr_counts();
        start_load(0, 1'b0);
        send_frame(0, bad, 1'b0);
        chk("bad_writes", 32'(wc[0]), 32'd2);
        chk("bad_error",  32'(if0.error), 32'd1);
        chk("bad_hold",   32'(if0.cpu_hold), 32'd1);
        chk("bad_pulses", 32'(sc[0]), 32'd0);
        chk("bad_ready",  32'(if0.in_ready), 32'd0);

        // Stalling upstream
        clr_counts();
        tmem0[0] = 32'd0; tmem0[1] = 32'd0;
        start_load(0, 1'b0);
        send_frame(0, good, 1'b1);
        chk("stall_mem0", tmem0[0], 32'h2801000A);
        chk("stall_mem1", tmem0[1], 32'h28020014);
        chk("stall_done", 32'(if0.done), 32'd1);
        chk("stall_pulses", 32'(sc[0]), 32'd1);

        // Empty image, with a byte presented alongside start in DONE
        clr_counts();
        start_load(0, 1'b1);
        fr = '{8'h00, 8'h00, 8'h00};
        send_frame(0, fr, 1'b0);
        chk("n0_done",   32'(if0.done), 32'd1);
        chk("n0_writes", 32'(wc[0]), 32'd0);
        chk("n0_words",  32'(if0.words_loaded), 32'd0);

        // Oversize on default width: N = 1025
        clr_counts();
        start_load(0, 1'b0);
        send(0, 8'h04, 1'b0);
        send(0, 8'h01, 1'b0);
        idle(0, 3);
        chk("big_error",  32'(if0.error), 32'd1);
        chk("big_writes", 32'(wc[0]), 32'd0);

        // ADDR_W=2: N=4 fills memory exactly
        clr_counts();
        start_load(1, 1'b0);
        fr = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
               8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h04};
        send_frame(1, fr, 1'b0);
        chk("full_mem0", tmem1[0], 32'h11223344);
        chk("full_mem1", tmem1[1], 32'h55667788);
        chk("full_mem2", tmem1[2], 32'h99AABBCC);
        chk("full_mem3", tmem1[3], 32'hDDEEFF00);
        chk("full_words", 32'(if1.words_loaded), 32'd4);
        chk("full_done",  32'(if1.done), 32'd1);

        // ADDR_W=2: N=5 rejected after N_lo
        clr_counts();
        start_load(1, 1'b0);
        send(1, 8'h00, 1'b0);
        send(1, 8'h05, 1'b0);
        idle(1, 3);
        chk("over_error",  32'(if1.error), 32'd1);
        chk("over_ready",  32'(if1.in_ready), 32'd0);
        chk("over_writes", 32'(wc[1]), 32'd0);
        chk("over_words",  32'(if1.words_loaded), 32'd0);

        // Reset after the 6th byte
        clr_counts();
        tmem0[0] = 32'd0; tmem0[1] = 32'd0;
        start_load(0, 1'b0);
        for (int i = 0; i < 6; i++) send(0, good[i], 1'b0);
        @(negedge clk1);
        v_i[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_ready", 32'(if0.in_ready), 32'd0);
        chk("mid_we",    32'(if0.mem_we), 32'd0);
        chk("mid_addr",  32'(if0.mem_addr), 32'd0);
        chk("mid_wdata", if0.mem_wdata, 32'd0);
        chk("mid_hold",  32'(if0.cpu_hold), 32'd1);
        chk("mid_words", 32'(if0.words_loaded), 32'd0);
        chk("mid_busy",  32'(if0.busy), 32'd0);
        chk("mid_mem0",  tmem0[0], 32'h2801000A);
        chk("mid_mem1",  tmem0[1], 32'h00000000);
        @(negedge clk1); #2 rst = 1'b0;

        // Restart, with start pulsed again mid-DATA
        clr_counts();
        start_load(0, 1'b0);
        for (int i = 0; i < 11; i++) send(0, good[i], (i == 4));
        idle(0, 2);
        chk("re_mem1",   tmem0[1], 32'h28020014);
        chk("re_done",   32'(if0.done), 32'd1);
        chk("re_words",  32'(if0.words_loaded), 32'd2);
        chk("re_pulses", 32'(sc[0]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finished");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
